branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
Consumer side of the ALU flag register. It takes a branch or jump request from the decoder, tests the condition code against the 5-bit flags (C,L,F,Z,N) the ALU writes, and returns the resolved next PC and any link value. The result is registered and delivered over a valid/ready handshake. It sits between the decoder/flag register and the PC/register-file write logic, and it stalls while an ALU flag update is in flight.

Parameters:
WIDTH, 16, datapath / PC width in bits
DISP_W, 8, width of the signed branch displacement

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request; high only in IDLE and while reset is low
req_kind  input  2  request kind: 00 Bcond (PC-relative), 01 Jcond (register target), 10 JAL (jump and link), 11 reserved
req_cond  input  4  condition code (encodings under Behaviour)
req_pc  input  WIDTH  PC of the branch instruction
req_disp  input  DISP_W  signed displacement, Bcond only
req_target  input  WIDTH  register target, Jcond/JAL only
flags  input  5  bit0 C, bit1 L, bit2 F (overflow), bit3 Z, bit4 N
flags_busy  input  1  an ALU flag write is pending; flags are not yet valid
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts the response
resp_taken  output  1  branch taken
resp_next_pc  output  WIDTH  resolved next PC
resp_link_we  output  1  write resp_link_value to the link register
resp_link_value  output  WIDTH  return address, req_pc+1

Behaviour:
- Reset (asynchronous, active-high):
  - state goes to IDLE.
  - resp_valid, resp_taken and resp_link_we go to 0; resp_next_pc and resp_link_value go to 0.
  - req_ready is 0 while reset is asserted.
  - A request in flight is discarded with no response.
- Condition codes, producing cond_true:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 HI: L
  - 0101 LS: !L
  - 0110 GT: N
  - 0111 LE: !N
  - 1000 FS: F
  - 1001 FC: !F
  - 1010 LO: !L & !Z
  - 1011 HS: L | Z
  - 1100 LT: !N & !Z
  - 1101 GE: N | Z
  - 1110 UC: 1
  - 1111 never: 0
- Resolution by req_kind:
  - Bcond: taken = cond_true. Next PC is req_pc + sign_extend(req_disp) when taken, else req_pc+1.
  - Jcond: taken = cond_true. Next PC is req_target when taken, else req_pc+1.
  - JAL: always taken; next PC = req_target; link_we=1; link_value = req_pc+1.
  - Reserved kind: taken=0; next PC = req_pc+1; link_we=0.
  - All additions are modulo 2^WIDTH, so 0xFFFF+1 = 0x0000 and the displacement wraps.
  - resp_link_value is req_pc+1 for every kind; only resp_link_we qualifies it.
- "Flags needed" means cond is not 1110 or 1111 and kind is Bcond or Jcond.
- State machine:
  - IDLE: req_ready=1. On req_valid & req_ready, all req_* fields are captured.
    - If flags are needed and flags_busy=1, go to WAIT_FLAGS.
    - Otherwise evaluate with the current flags, register the result at the same edge, and go to RESP.
  - WAIT_FLAGS: req_ready=0. Hold the captured request.
    - On the first edge with flags_busy=0, evaluate with the flags sampled at that edge and go to RESP.
  - RESP: resp_valid=1; all resp_* outputs are stable and registered. req_ready=0.
    - When resp_ready=1, go to IDLE; resp_valid drops the next cycle.
- Latency:
  - With no flag stall, resp_valid is asserted the cycle after acceptance.
  - With a stall, resp_valid is asserted the cycle after the edge where flags_busy is sampled 0.
- Throughput: at most one request per 2 cycles; no acceptance while RESP is occupied.
- resp_ready asserted outside RESP is ignored.
- req_* inputs are ignored in WAIT_FLAGS and RESP.
- Changes on flags or flags_busy while in RESP do not alter the held response.
- No combinational path from any input to any resp_* output.

Test Plan:
1. Bcond EQ, flags=5'b01000, pc=0x0010, disp=0xFC -> resp_valid 1 cycle after accept; taken=1, next_pc=0x000C, link_we=0.
2. Same request with flags=5'b00000 -> taken=0, next_pc=0x0011.
3. Wrap cases:
   - Bcond UC, pc=0xFFFF, disp=0x01 -> next_pc=0x0000, taken=1.
   - Bcond cond=1111, pc=0xFFFF -> taken=0, next_pc=0x0000.
4. Flag stall:
   - Jcond LO, target=0x1234, flags_busy=1 for 3 cycles, then flags=5'b00000 -> stays in WAIT_FLAGS, req_ready=0.
   - resp_valid 1 cycle after busy is sampled low; taken=1, next_pc=0x1234.
   - Repeat with flags=5'b01000 -> taken=0, next_pc=pc+1.
5. JAL, pc=0x0100, target=0x0200, flags_busy=1, resp_ready low for 4 cycles:
   - No stall occurs.
   - Outputs hold taken=1, next_pc=0x0200, link_we=1, link_value=0x0101.
   - req_ready=0 until the handshake, then 1.
6. Reset asserted asynchronously during WAIT_FLAGS -> resp_valid=0 and all resp_* = 0 immediately. After release, a new UC Bcond is served normally. A sweep of all 16 conds over all 32 flag values matches the condition-code encodings above.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch/jump resolver: tests a condition code against the ALU flags and
// returns the registered next PC and link value over a valid/ready handshake.
//
// state  | meaning
// IDLE   | ready for a request; evaluates at once unless flags are in flight
// WAIT   | request captured, waiting for flags_busy to clear
// RESP   | registered response held until resp_ready
module branch_resolve_unit #(
  parameter int WIDTH  = 16,
  parameter int DISP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_kind,
  input  logic [3:0]        req_cond,
  input  logic [WIDTH-1:0]  req_pc,
  input  logic [DISP_W-1:0] req_disp,
  input  logic [WIDTH-1:0]  req_target,
  input  logic [4:0]        flags,
  input  logic              flags_busy,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_taken,
  output logic [WIDTH-1:0]  resp_next_pc,
  output logic              resp_link_we,
  output logic [WIDTH-1:0]  resp_link_value
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] K_BCOND = 2'b00;
  localparam logic [1:0] K_JCOND = 2'b01;
  localparam logic [1:0] K_JAL   = 2'b10;

  logic [1:0]        r_state;
  logic [1:0]        r_kind;
  logic [3:0]        r_cond;
  logic [WIDTH-1:0]  r_pc;
  logic [DISP_W-1:0] r_disp;
  logic [WIDTH-1:0]  r_target;
  logic              r_taken;
  logic [WIDTH-1:0]  r_next_pc;
  logic              r_link_we;
  logic [WIDTH-1:0]  r_link_value;

  logic [1:0]        w_kind;
  logic [3:0]        w_cond;
  logic [WIDTH-1:0]  w_pc;
  logic [DISP_W-1:0] w_disp;
  logic [WIDTH-1:0]  w_target;
  logic [WIDTH-1:0]  w_pc_inc;
  logic [WIDTH-1:0]  w_disp_ext;
  logic              w_c, w_l, w_f, w_z, w_n;
  logic              w_cond_true;
  logic              w_flags_needed;
  logic              w_taken;
  logic              w_link_we;
  logic [WIDTH-1:0]  w_next_pc;
  logic              w_idle;
  logic              w_accept;

  assign w_idle     = (r_state == S_IDLE);
  assign w_accept   = req_valid & w_idle;
  assign req_ready  = w_idle & ~reset;
  assign resp_valid = (r_state == S_RESP);

  // In IDLE the live request is evaluated; afterwards the captured copy is.
  assign w_kind   = w_idle ? req_kind   : r_kind;
  assign w_cond   = w_idle ? req_cond   : r_cond;
  assign w_pc     = w_idle ? req_pc     : r_pc;
  assign w_disp   = w_idle ? req_disp   : r_disp;
  assign w_target = w_idle ? req_target : r_target;

  assign w_pc_inc   = w_pc + WIDTH'(1);
  assign w_disp_ext = {{(WIDTH-DISP_W){w_disp[DISP_W-1]}}, w_disp};

  assign w_c = flags[0];
  assign w_l = flags[1];
  assign w_f = flags[2];
  assign w_z = flags[3];
  assign w_n = flags[4];

  always_comb begin
    w_cond_true = 1'b0;
    case (w_cond)
      4'h0: w_cond_true = w_z;
      4'h1: w_cond_true = ~w_z;
      4'h2: w_cond_true = w_c;
      4'h3: w_cond_true = ~w_c;
      4'h4: w_cond_true = w_l;
      4'h5: w_cond_true = ~w_l;
      4'h6: w_cond_true = w_n;
      4'h7: w_cond_true = ~w_n;
      4'h8: w_cond_true = w_f;
      4'h9: w_cond_true = ~w_f;
      4'hA: w_cond_true = ~w_l & ~w_z;
      4'hB: w_cond_true = w_l | w_z;
      4'hC: w_cond_true = ~w_n & ~w_z;
      4'hD: w_cond_true = w_n | w_z;
      4'hE: w_cond_true = 1'b1;
      default: w_cond_true = 1'b0;
    endcase
  end

  assign w_flags_needed = (w_cond[3:1] != 3'b111) &&
                          ((w_kind == K_BCOND) || (w_kind == K_JCOND));

  always_comb begin
    w_taken   = 1'b0;
    w_link_we = 1'b0;
    w_next_pc = w_pc_inc;
    case (w_kind)
      K_BCOND: begin
        w_taken = w_cond_true;
        if (w_cond_true) w_next_pc = w_pc + w_disp_ext;
      end
      K_JCOND: begin
        w_taken = w_cond_true;
        if (w_cond_true) w_next_pc = w_target;
      end
      K_JAL: begin
        w_taken   = 1'b1;
        w_link_we = 1'b1;
        w_next_pc = w_target;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_kind       <= '0;
      r_cond       <= '0;
      r_pc         <= '0;
      r_disp       <= '0;
      r_target     <= '0;
      r_taken      <= 1'b0;
      r_next_pc    <= '0;
      r_link_we    <= 1'b0;
      r_link_value <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_kind   <= req_kind;
            r_cond   <= req_cond;
            r_pc     <= req_pc;
            r_disp   <= req_disp;
            r_target <= req_target;
            if (w_flags_needed && flags_busy) begin
              r_state <= S_WAIT;
            end else begin
              r_taken      <= w_taken;
              r_next_pc    <= w_next_pc;
              r_link_we    <= w_link_we;
              r_link_value <= w_pc_inc;
              r_state      <= S_RESP;
            end
          end
        end
        S_WAIT: begin
          if (!flags_busy) begin
            r_taken      <= w_taken;
            r_next_pc    <= w_next_pc;
            r_link_we    <= w_link_we;
            r_link_value <= w_pc_inc;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign resp_taken      = r_taken;
  assign resp_next_pc    = r_next_pc;
  assign resp_link_we    = r_link_we;
  assign resp_link_value = r_link_value;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: latency, wrap, flag stall, JAL hold,
// async reset and a full condition-code sweep against a reference table.
module tb_branch_resolve_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_kind;
  logic [3:0]  req_cond;
  logic [15:0] req_pc;
  logic [7:0]  req_disp;
  logic [15:0] req_target;
  logic [4:0]  flags;
  logic        flags_busy;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_taken;
  logic [15:0] resp_next_pc;
  logic        resp_link_we;
  logic [15:0] resp_link_value;

  int n_total;
  int n_bad;

  branch_resolve_unit #(.WIDTH(16), .DISP_W(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_cond(req_cond), .req_pc(req_pc),
    .req_disp(req_disp), .req_target(req_target),
    .flags(flags), .flags_busy(flags_busy),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_taken(resp_taken), .resp_next_pc(resp_next_pc),
    .resp_link_we(resp_link_we), .resp_link_value(resp_link_value)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference table of condition encodings; flags = {N,Z,F,L,C}.
  function automatic logic ref_cond(input logic [3:0] c, input logic [4:0] f);
    logic fc, fl, ff, fz, fn;
    {fn, fz, ff, fl, fc} = f;
    case (c)
      4'd0:  return fz;
      4'd1:  return !fz;
      4'd2:  return fc;
      4'd3:  return !fc;
      4'd4:  return fl;
      4'd5:  return !fl;
      4'd6:  return fn;
      4'd7:  return !fn;
      4'd8:  return ff;
      4'd9:  return !ff;
      4'd10: return !fl && !fz;
      4'd11: return fl || fz;
      4'd12: return !fn && !fz;
      4'd13: return fn || fz;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Presents one request for a single edge, then scrambles the req_* bus.
  task automatic issue(input logic [1:0] k, input logic [3:0] c, input logic [15:0] pc,
                       input logic [7:0] d, input logic [15:0] t,
                       input logic [4:0] f, input logic busy);
    @(negedge clk);
    req_valid  = 1'b1;
    req_kind   = k;
    req_cond   = c;
    req_pc     = pc;
    req_disp   = d;
    req_target = t;
    flags      = f;
    flags_busy = busy;
    chk("ready_before_accept", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid  = 1'b0;
    req_kind   = 2'b10;
    req_cond   = 4'hE;
    req_pc     = 16'hDEAD;
    req_disp   = 8'h7F;
    req_target = 16'hBEEF;
  endtask

  task automatic check_resp(input string tag, input logic tk, input logic [15:0] npc,
                            input logic lwe, input logic [15:0] lval);
    chk({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, "_taken"}, {31'd0, resp_taken}, {31'd0, tk});
    chk({tag, "_next_pc"}, {16'd0, resp_next_pc}, {16'd0, npc});
    chk({tag, "_link_we"}, {31'd0, resp_link_we}, {31'd0, lwe});
    chk({tag, "_link_val"}, {16'd0, resp_link_value}, {16'd0, lval});
  endtask

  task automatic finish_resp(input string tag);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    n_total    = 0;
    n_bad      = 0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_kind   = 2'b00;
    req_cond   = 4'h0;
    req_pc     = 16'h0;
    req_disp   = 8'h0;
    req_target = 16'h0;
    flags      = 5'b0;
    flags_busy = 1'b0;
    resp_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_next_pc", {16'd0, resp_next_pc}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", {31'd0, req_ready}, 32'd1);

    // Stray resp_ready in IDLE is ignored.
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("idle_ready_ignored", {31'd0, req_ready}, 32'd1);

    // Bcond EQ, Z set: 0x0010 + (-4)
    issue(2'b00, 4'h0, 16'h0010, 8'hFC, 16'h0, 5'b01000, 1'b0);
    check_resp("t1", 1'b1, 16'h000C, 1'b0, 16'h0011);
    chk("t1_ready_low", {31'd0, req_ready}, 32'd0);
    finish_resp("t1");

    issue(2'b00, 4'h0, 16'h0010, 8'hFC, 16'h0, 5'b00000, 1'b0);
    check_resp("t2", 1'b0, 16'h0011, 1'b0, 16'h0011);
    finish_resp("t2");

    issue(2'b00, 4'hE, 16'hFFFF, 8'h01, 16'h0, 5'b00000, 1'b0);
    check_resp("t3a", 1'b1, 16'h0000, 1'b0, 16'h0000);
    finish_resp("t3a");

    issue(2'b00, 4'hF, 16'hFFFF, 8'h01, 16'h0, 5'b11111, 1'b0);
    check_resp("t3b", 1'b0, 16'h0000, 1'b0, 16'h0000);
    finish_resp("t3b");

    // Jcond LO with flag stall; stale flags would make it not-taken.
    issue(2'b01, 4'hA, 16'h0050, 8'h00, 16'h1234, 5'b01000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("t4a_wait_valid", {31'd0, resp_valid}, 32'd0);
      chk("t4a_wait_ready", {31'd0, req_ready}, 32'd0);
      if (i < 2) @(negedge clk);
    end
    flags_busy = 1'b0;
    flags      = 5'b00000;
    @(negedge clk);
    check_resp("t4a", 1'b1, 16'h1234, 1'b0, 16'h0051);
    flags      = 5'b01000;
    flags_busy = 1'b1;
    @(negedge clk);
    check_resp("t4a_hold", 1'b1, 16'h1234, 1'b0, 16'h0051);
    finish_resp("t4a");

    issue(2'b01, 4'hA, 16'h0050, 8'h00, 16'h1234, 5'b00000, 1'b1);
    repeat (2) @(negedge clk);
    chk("t4b_wait_valid", {31'd0, resp_valid}, 32'd0);
    flags_busy = 1'b0;
    flags      = 5'b01000;
    @(negedge clk);
    check_resp("t4b", 1'b0, 16'h0051, 1'b0, 16'h0051);
    finish_resp("t4b");

    // JAL never stalls; response held while consumer is not ready.
    issue(2'b10, 4'h0, 16'h0100, 8'h00, 16'h0200, 5'b00000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check_resp("t5", 1'b1, 16'h0200, 1'b1, 16'h0101);
      chk("t5_ready_low", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    finish_resp("t5");
    flags_busy = 1'b0;

    // Reserved kind.
    issue(2'b11, 4'hE, 16'h0300, 8'h10, 16'h0400, 5'b11111, 1'b0);
    check_resp("rsv", 1'b0, 16'h0301, 1'b0, 16'h0301);
    finish_resp("rsv");

    // Async reset during WAIT clears the held registers immediately.
    issue(2'b01, 4'h0, 16'h0600, 8'h00, 16'h0700, 5'b01000, 1'b1);
    chk("t6_in_wait", {31'd0, resp_valid}, 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("t6_rst_taken", {31'd0, resp_taken}, 32'd0);
    chk("t6_rst_next_pc", {16'd0, resp_next_pc}, 32'd0);
    chk("t6_rst_link_we", {31'd0, resp_link_we}, 32'd0);
    chk("t6_rst_link_val", {16'd0, resp_link_value}, 32'd0);
    chk("t6_rst_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    reset      = 1'b0;
    flags_busy = 1'b0;
    @(negedge clk);
    chk("t6_no_stale_resp", {31'd0, resp_valid}, 32'd0);
    issue(2'b00, 4'hE, 16'h0020, 8'h05, 16'h0, 5'b00000, 1'b0);
    check_resp("t6_after", 1'b1, 16'h0025, 1'b0, 16'h0021);
    finish_resp("t6_after");

    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 32; f++) begin
        logic exp_t;
        exp_t = ref_cond(4'(c), 5'(f));
        issue(2'b01, 4'(c), 16'h0700, 8'h00, 16'h0ABC, 5'(f), 1'b0);
        chk($sformatf("sweep_c%0d_f%0d_taken", c, f), {31'd0, resp_taken}, {31'd0, exp_t});
        chk($sformatf("sweep_c%0d_f%0d_npc", c, f), {16'd0, resp_next_pc},
            exp_t ? 32'h0ABC : 32'h0701);
        finish_resp("sweep");
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
